// File: rtl/diffeq_pkg.sv
// diffeq_pkg
// Shared widths and sample types for the difference-equation filter and
// its output stage.
//   DIFFEQ_Y_BITS      : width of the filter output y[n] (filter N_BITS + 3)
//   DIFFEQ_SAMPLE_BITS : width of the system sample handed to the DAC/UART
package diffeq_pkg;

  localparam int DIFFEQ_Y_BITS      = 11;
  localparam int DIFFEQ_SAMPLE_BITS = 8;

  // Wide filter output and narrow system sample, both two's complement.
  typedef logic signed [DIFFEQ_Y_BITS-1:0]      diffeq_y_t;
  typedef logic signed [DIFFEQ_SAMPLE_BITS-1:0] diffeq_sample_t;

endpackage

// File: rtl/diffeq_sync_fifo.sv
// diffeq_sync_fifo
// Single-clock FIFO with a registered storage array and head read-out.
// Parameters: WIDTH (entry width), DEPTH (entries, power of 2, >= 2).
// Ports:
//   clock, i_reset : clock and synchronous active-high reset
//   push, wr_data  : write request and data
//   pop            : read request (head advances)
//   rd_data        : current head entry (storage is cleared on reset)
//   full, empty    : occupancy flags
module diffeq_sync_fifo
  import diffeq_pkg::*;
#(
  parameter int WIDTH = DIFFEQ_SAMPLE_BITS,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             i_reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             pop_ok_s;
  logic             push_ok_s;

  assign full  = (count_r == CW'(DEPTH));
  assign empty = (count_r == CW'(0));

  // A pop on an empty FIFO is ignored; a push on a full FIFO needs a
  // same-cycle pop, which frees the slot the write pointer lands on.
  assign pop_ok_s  = pop && !empty;
  assign push_ok_s = push && (!full || pop_ok_s);

  assign rd_data = mem_r[rd_ptr_r];

  // Storage array: cleared on reset, written at the tail on push.
  always_ff @(posedge clock) begin
    if (i_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers wrap naturally; occupancy count holds on push+pop.
  always_ff @(posedge clock) begin
    if (i_reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/diffeq_output_stage.sv
// diffeq_output_stage
// Saturates the wide filter output to the system sample width, buffers it
// in a FIFO toward a valid/ready consumer, and keeps saturation and drop
// statistics.
// Build option: DIFFEQ_INSTAB_DETECT_EN enables the sticky instability
// alarm (ALARM_LEN consecutive saturated samples); otherwise o_alarm is 0.
// Ports:
//   clock, i_reset      : clock and synchronous active-high reset
//   i_y, i_valid        : filter output sample and its strobe
//   o_data, o_valid     : FIFO head sample and non-empty flag
//   i_ready             : consumer accepts o_data
//   o_sat_cnt           : saturated-sample count (sticks at 0xFFFF)
//   o_drop_cnt          : samples dropped on a full FIFO (sticks at 0xFF)
//   o_alarm             : sticky instability alarm
module diffeq_output_stage
  import diffeq_pkg::*;
#(
  parameter int IN_BITS    = DIFFEQ_Y_BITS,
  parameter int OUT_BITS   = DIFFEQ_SAMPLE_BITS,
  parameter int FIFO_DEPTH = 4,
  parameter int ALARM_LEN  = 8
) (
  input  logic                clock,
  input  logic                i_reset,
  input  logic [IN_BITS-1:0]  i_y,
  input  logic                i_valid,
  output logic [OUT_BITS-1:0] o_data,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [15:0]         o_sat_cnt,
  output logic [7:0]          o_drop_cnt,
  output logic                o_alarm
);

  logic [IN_BITS-OUT_BITS-1:0] ext_s;
  logic                        sat_hi_s;
  logic                        sat_lo_s;
  logic                        sat_s;
  logic [OUT_BITS-1:0]         sample_s;
  logic                        full_s;
  logic                        empty_s;
  logic                        pop_s;
  logic                        push_s;
  logic                        drop_s;
  logic [15:0]                 sat_cnt_r;
  logic [7:0]                  drop_cnt_r;

  // The value fits in OUT_BITS only if every bit above the new sign bit
  // repeats the sign; otherwise the sign says which rail to clip to.
  assign ext_s    = i_y[IN_BITS-2:OUT_BITS-1];
  assign sat_hi_s = !i_y[IN_BITS-1] && (ext_s != '0);
  assign sat_lo_s = i_y[IN_BITS-1] && (ext_s != '1);
  assign sat_s    = sat_hi_s || sat_lo_s;

  // Clip to max positive / max negative, or keep the low bits.
  always_comb begin
    sample_s = i_y[OUT_BITS-1:0];
    if (sat_hi_s) begin
      sample_s = {1'b0, {(OUT_BITS-1){1'b1}}};
    end else if (sat_lo_s) begin
      sample_s = {1'b1, {(OUT_BITS-1){1'b0}}};
    end else begin
      sample_s = i_y[OUT_BITS-1:0];
    end
  end

  assign o_valid = !empty_s;
  assign pop_s   = o_valid && i_ready;
  assign push_s  = i_valid && (!full_s || pop_s);
  assign drop_s  = i_valid && full_s && !pop_s;

  diffeq_sync_fifo #(
    .WIDTH (OUT_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .i_reset (i_reset),
    .push    (push_s),
    .pop     (pop_s),
    .wr_data (sample_s),
    .rd_data (o_data),
    .full    (full_s),
    .empty   (empty_s)
  );

  // Saturation and drop counters, both holding at their maximum.
  always_ff @(posedge clock) begin
    if (i_reset) begin
      sat_cnt_r  <= 16'h0000;
      drop_cnt_r <= 8'h00;
    end else begin
      if (i_valid && sat_s && (sat_cnt_r != 16'hFFFF)) begin
        sat_cnt_r <= sat_cnt_r + 16'h0001;
      end
      if (drop_s && (drop_cnt_r != 8'hFF)) begin
        drop_cnt_r <= drop_cnt_r + 8'h01;
      end
    end
  end

  assign o_sat_cnt  = sat_cnt_r;
  assign o_drop_cnt = drop_cnt_r;

`ifdef DIFFEQ_INSTAB_DETECT_EN
  localparam int RW = $clog2(ALARM_LEN + 1);

  logic [RW-1:0] run_r;
  logic [RW-1:0] run_nxt_s;
  logic          alarm_r;

  // Consecutive-saturation run length, parked at ALARM_LEN.
  always_comb begin
    run_nxt_s = run_r;
    if (i_valid) begin
      if (!sat_s) begin
        run_nxt_s = '0;
      end else if (run_r != RW'(ALARM_LEN)) begin
        run_nxt_s = run_r + RW'(1);
      end else begin
        run_nxt_s = run_r;
      end
    end else begin
      run_nxt_s = run_r;
    end
  end

  // Run counter and sticky alarm; the alarm sets on the edge the run
  // reaches ALARM_LEN and only a reset clears it.
  always_ff @(posedge clock) begin
    if (i_reset) begin
      run_r   <= '0;
      alarm_r <= 1'b0;
    end else begin
      run_r <= run_nxt_s;
      if (run_nxt_s == RW'(ALARM_LEN)) begin
        alarm_r <= 1'b1;
      end
    end
  end

  assign o_alarm = alarm_r;
`else
  logic [31:0] alarm_len_unused_s;
  assign alarm_len_unused_s = 32'(ALARM_LEN);
  assign o_alarm = 1'b0;
`endif

endmodule

// File: tb/tb_diffeq_output_stage.sv
// tb_diffeq_output_stage
// Directed bench for diffeq_output_stage at default parameters. Expected
// alarm behaviour follows DIFFEQ_INSTAB_DETECT_EN as seen by this file.
module tb_diffeq_output_stage;

  logic        clock;
  logic        i_reset;
  logic [10:0] i_y;
  logic        i_valid;
  logic [7:0]  o_data;
  logic        o_valid;
  logic        i_ready;
  logic [15:0] o_sat_cnt;
  logic [7:0]  o_drop_cnt;
  logic        o_alarm;

  int checks_n;
  int errors_n;

`ifdef DIFFEQ_INSTAB_DETECT_EN
  localparam bit ALARM_ON = 1'b1;
`else
  localparam bit ALARM_ON = 1'b0;
`endif

  diffeq_output_stage dut (
    .clock      (clock),
    .i_reset    (i_reset),
    .i_y        (i_y),
    .i_valid    (i_valid),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_sat_cnt  (o_sat_cnt),
    .o_drop_cnt (o_drop_cnt),
    .o_alarm    (o_alarm)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_n++;
    if (got !== exp) begin
      errors_n++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  logic [10:0] clip_in  [5];
  logic [7:0]  clip_out [5];

  initial begin
    checks_n = 0;
    errors_n = 0;
    clip_in[0] = 11'h07F; clip_out[0] = 8'h7F;
    clip_in[1] = 11'h080; clip_out[1] = 8'h7F;
    clip_in[2] = 11'h780; clip_out[2] = 8'h80;
    clip_in[3] = 11'h77F; clip_out[3] = 8'h80;
    clip_in[4] = 11'h7FF; clip_out[4] = 8'hFF;

    i_reset = 1'b1;
    i_y     = 11'h000;
    i_valid = 1'b0;
    i_ready = 1'b0;
    tick();
    tick();
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_data",  32'(o_data), 32'd0);
    chk("rst_sat",   32'(o_sat_cnt), 32'd0);
    chk("rst_drop",  32'(o_drop_cnt), 32'd0);
    chk("rst_alarm", 32'(o_alarm), 32'd0);
    i_reset = 1'b0;

    // Clip boundaries, streaming with the consumer always ready.
    i_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      i_valid = 1'b1;
      i_y     = clip_in[k];
      tick();
      chk("clip_valid", 32'(o_valid), 32'd1);
      chk("clip_data",  32'(o_data), 32'(clip_out[k]));
    end
    chk("clip_sat_cnt", 32'(o_sat_cnt), 32'd2);
    i_valid = 1'b0;
    tick();
    chk("clip_drain", 32'(o_valid), 32'd0);

    // Fill and drop with the consumer stalled.
    i_ready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      i_valid = 1'b1;
      i_y     = 11'(k);
      tick();
      chk("fill_valid", 32'(o_valid), 32'd1);
      chk("fill_head",  32'(o_data), 32'd1);
    end
    chk("fill_drop_cnt", 32'(o_drop_cnt), 32'd2);
    i_valid = 1'b0;
    i_ready = 1'b1;
    for (int k = 2; k <= 4; k++) begin
      tick();
      chk("drain_data", 32'(o_data), 32'(k));
    end
    tick();
    chk("drain_empty", 32'(o_valid), 32'd0);

    // Full FIFO with push and pop in the same cycle.
    i_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      i_valid = 1'b1;
      i_y     = 11'(k);
      tick();
    end
    chk("full_head", 32'(o_data), 32'd1);
    i_y     = 11'd9;
    i_ready = 1'b1;
    tick();
    chk("pp_head",  32'(o_data), 32'd2);
    chk("pp_drop",  32'(o_drop_cnt), 32'd2);
    chk("pp_valid", 32'(o_valid), 32'd1);
    i_valid = 1'b0;
    tick();
    chk("pp_pop3", 32'(o_data), 32'd3);
    tick();
    chk("pp_pop4", 32'(o_data), 32'd4);
    tick();
    chk("pp_pop9", 32'(o_data), 32'd9);
    tick();
    chk("pp_empty", 32'(o_valid), 32'd0);

    // Instability alarm: a broken run of 7, then a full run of 8.
    i_ready = 1'b1;
    i_valid = 1'b1;
    for (int k = 0; k < 7; k++) begin
      i_y = 11'h200;
      tick();
      chk("alarm_run7", 32'(o_alarm), 32'd0);
    end
    i_y = 11'h010;
    tick();
    chk("alarm_break", 32'(o_alarm), 32'd0);
    for (int k = 1; k <= 8; k++) begin
      i_y = 11'h200;
      tick();
      chk("alarm_run8", 32'(o_alarm), 32'(ALARM_ON && (k == 8)));
    end
    i_y = 11'h010;
    tick();
    tick();
    chk("alarm_sticky", 32'(o_alarm), 32'(ALARM_ON));
    chk("alarm_sat_cnt", 32'(o_sat_cnt), 32'd17);

    // Reset mid-stream with three samples queued and a handshake pending.
    i_valid = 1'b0;
    tick();
    chk("pre_empty", 32'(o_valid), 32'd0);
    i_ready = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      i_valid = 1'b1;
      i_y     = 11'(k);
      tick();
    end
    chk("pre_rst_head", 32'(o_data), 32'd1);
    i_reset = 1'b1;
    i_ready = 1'b1;
    i_y     = 11'h300;
    tick();
    i_reset = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b0;
    chk("mid_rst_valid", 32'(o_valid), 32'd0);
    chk("mid_rst_data",  32'(o_data), 32'd0);
    chk("mid_rst_sat",   32'(o_sat_cnt), 32'd0);
    chk("mid_rst_drop",  32'(o_drop_cnt), 32'd0);
    chk("mid_rst_alarm", 32'(o_alarm), 32'd0);
    i_valid = 1'b1;
    i_y     = 11'h005;
    tick();
    i_valid = 1'b0;
    chk("post_rst_valid", 32'(o_valid), 32'd1);
    chk("post_rst_data",  32'(o_data), 32'd5);

    $display("CHECKS %0d ERRORS %0d", checks_n, errors_n);
    $finish;
  end

endmodule
